// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game score/display slice.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    LOST    = 2'd2
  } game_state_t;

  // Largest 4-digit BCD score; the counter sticks here instead of wrapping.
  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Blink phases on which the display shows a message (odd phases are blank).
  localparam logic [1:0] BLINK_MSG_A = 2'd0;
  localparam logic [1:0] BLINK_MSG_B = 2'd2;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: produces a one-cycle enable every DIV clocks.
// The counter runs 0..DIV-1 and the tick is registered on the wrap, so the
// first tick appears DIV cycles after reset is released.
module tick_divider
  import flappy_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic          tick_reg;

  // Count clocks and flag the wrap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      tick_reg <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/game_score_ctrl.sv
// Game state machine (IDLE/PLAYING/LOST), 4-digit BCD score counter and the
// scan/blink enables consumed by the seven-segment display driver.
// Optional feature: define HIGH_SCORE_EN to keep a best-score register;
// without it high_bcd is constant zero.
module game_score_ctrl
  import flappy_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000,
  parameter int LOST_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pass_pulse,
  input  logic        collide,
  output logic        lost,
  output logic        playing,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic        scan_tick,
  output logic        blink_tick,
  output logic [1:0]  blink_phase
);

  localparam logic [3:0] HOLD_MIN = 4'(LOST_HOLD);
  localparam logic [3:0] HOLD_SAT = 4'd15;

  game_state_t state_reg, state_next;
  logic        start_q_reg;
  logic [15:0] score_reg;
  logic [15:0] score_inc;
  logic [3:0]  hold_cnt_reg;
  logic [1:0]  blink_phase_reg;
  logic        start_rise;
  logic        hold_done;
  logic        game_start;
  logic        game_over;
  logic        score_step;
  logic [3:0]  carry;

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk  (clk),
    .rst  (rst),
    .tick (blink_tick)
  );

  assign start_rise = start_btn & ~start_q_reg;
  assign hold_done  = (hold_cnt_reg >= HOLD_MIN);
  assign game_start = (state_reg != PLAYING) && (state_next == PLAYING);
  assign game_over  = (state_reg == PLAYING) && (state_next == LOST);
  // A collide in the same cycle as a pass takes precedence: no point scored.
  assign score_step = (state_reg == PLAYING) && pass_pulse && !collide &&
                      (score_reg != BCD_MAX);

  // Per-digit BCD ripple increment; carry into a digit only when all lower digits are 9.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < 4; gi++) begin : g_bcd_digit
    assign score_inc[gi*4 +: 4] = carry[gi]
                                  ? ((score_reg[gi*4 +: 4] == 4'd9) ? 4'd0 : score_reg[gi*4 +: 4] + 4'd1)
                                  : score_reg[gi*4 +: 4];
    if (gi < 3) begin : g_carry
      assign carry[gi+1] = carry[gi] & (score_reg[gi*4 +: 4] == 4'd9);
    end
  end

  // State register and start-button edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      start_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      start_q_reg <= start_btn;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_rise)              state_next = PLAYING;
      PLAYING: if (collide)                 state_next = LOST;
      LOST:    if (start_rise && hold_done) state_next = PLAYING;
      default:                              state_next = IDLE;
    endcase
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    lost    = 1'b0;
    playing = 1'b0;
    case (state_reg)
      PLAYING: playing = 1'b1;
      LOST:    lost    = 1'b1;
      default: ;
    endcase
  end

  // Score: cleared when a game starts, stepped on accepted passes.
  always_ff @(posedge clk) begin
    if (rst || game_start) begin
      score_reg <= '0;
    end else if (score_step) begin
      score_reg <= score_inc;
    end
  end

  // Restart hold-off counter and blink phase, both live only while LOST.
  always_ff @(posedge clk) begin
    if (rst || state_reg != LOST) begin
      hold_cnt_reg <= '0;
    end else if (blink_tick && hold_cnt_reg != HOLD_SAT) begin
      hold_cnt_reg <= hold_cnt_reg + 4'd1;
    end

    if (rst || state_reg != LOST || state_next != LOST) begin
      blink_phase_reg <= BLINK_MSG_A;
    end else if (blink_tick) begin
      blink_phase_reg <= blink_phase_reg + 2'd1;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [15:0] high_reg;

  // Best score: captured at game over when beaten (BCD orders like binary).
  always_ff @(posedge clk) begin
    if (rst) begin
      high_reg <= '0;
    end else if (game_over && (score_reg > high_reg)) begin
      high_reg <= score_reg;
    end
  end

  assign high_bcd = high_reg;
`else
  assign high_bcd = 16'h0000;
`endif

  assign score_bcd   = score_reg;
  assign blink_phase = blink_phase_reg;

endmodule
